rgb_fade_ctrl: RTL

Sequencer for three pwm channels (R, G, B) that share one strobe.
- Generates the common pwm strobe from a programmable prescaler.
- Accepts colour commands over a valid/ready handshake.
- Ramps each channel's level by one LSB per fade tick toward the commanded target. Level changes are aligned to pwm period boundaries.
- Sits between the control/register front end and the three pwm instances; its level outputs feed the pwm level inputs directly.

---
 rtl/rgb_fade_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/rgb_fade_ctrl.sv
// rgb_fade_ctrl: common pwm strobe generator and colour fade sequencer
// for three pwm channels. It accepts colour commands over valid/ready and
// walks each channel's level one LSB per fade tick toward its target, with
// level changes landing just after a pwm period boundary.
module rgb_fade_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8,
  parameter int FADE_W     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PRESCALE_W-1:0] strobe_div,
  input  logic [FADE_W-1:0]     fade_div,
  output logic                  pwm_strobe,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [WIDTH-1:0]      cmd_r,
  input  logic [WIDTH-1:0]      cmd_g,
  input  logic [WIDTH-1:0]      cmd_b,
  input  logic                  cmd_instant,
  output logic [WIDTH-1:0]      level_r,
  output logic [WIDTH-1:0]      level_g,
  output logic [WIDTH-1:0]      level_b,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [PRESCALE_W-1:0]   pre_cnt_q, pre_cnt_d;
  logic                    strobe_q, strobe_d;
  logic [WIDTH-1:0]        per_cnt_q, per_cnt_d;
  logic [FADE_W-1:0]       fade_cnt_q, fade_cnt_d;
  logic [WIDTH-1:0]        tgt_r_q, tgt_r_d, tgt_g_q, tgt_g_d, tgt_b_q, tgt_b_d;
  logic [WIDTH-1:0]        lvl_r_q, lvl_r_d, lvl_g_q, lvl_g_d, lvl_b_q, lvl_b_d;
  logic                    done_q, done_d;

  logic                    period_wrap;
  logic                    fade_tick;
  logic                    accept;
  logic [WIDTH-1:0]        step_r, step_g, step_b;

  // Moves a level one LSB toward its target; an equal level stays put, so
  // the ramp can never overshoot or wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    if (cur < tgt)      return cur + 1'b1;
    else if (cur > tgt) return cur - 1'b1;
    else                return cur;
  endfunction

  assign period_wrap = strobe_q && (per_cnt_q == {WIDTH{1'b1}});
  assign fade_tick   = period_wrap && (fade_cnt_q == fade_div);
  assign accept      = cmd_valid && (state_q == IDLE);
  assign step_r      = step_toward(lvl_r_q, tgt_r_q);
  assign step_g      = step_toward(lvl_g_q, tgt_g_q);
  assign step_b      = step_toward(lvl_b_q, tgt_b_q);

  // Prescaler: count up to strobe_div, then emit a one-cycle strobe and restart.
  // A strobe_div lowered below the running count lets it run on and wrap.
  always_comb begin
    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    pre_cnt_d = pre_cnt_q + 1'b1;
    strobe_d  = 1'b0;
    if (pre_cnt_q == strobe_div) begin
      pre_cnt_d = '0;
      strobe_d  = 1'b1;
    end
  end

  // Period tracker mirrors the pwm counters; fade divider counts period wraps
  // and restarts on every accepted command so a new fade gets a fresh phase.
  always_comb begin
    per_cnt_d  = strobe_q ? per_cnt_q + 1'b1 : per_cnt_q;
    fade_cnt_d = fade_cnt_q;
    if (accept) begin
      fade_cnt_d = '0;
    end else if (period_wrap) begin
      fade_cnt_d = fade_tick ? '0 : fade_cnt_q + 1'b1;
    end
  end

  // Command FSM: latch targets on accept, apply instantly or ramp on fade ticks.
  always_comb begin
    state_d = state_q;
    tgt_r_d = tgt_r_q;
    tgt_g_d = tgt_g_q;
    tgt_b_d = tgt_b_q;
    lvl_r_d = lvl_r_q;
    lvl_g_d = lvl_g_q;
    lvl_b_d = lvl_b_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_r_d = cmd_r;
          tgt_g_d = cmd_g;
          tgt_b_d = cmd_b;
          if (cmd_instant) begin
            lvl_r_d = cmd_r;
            lvl_g_d = cmd_g;
            lvl_b_d = cmd_b;
            done_d  = 1'b1;
          end else if (cmd_r == lvl_r_q && cmd_g == lvl_g_q && cmd_b == lvl_b_q) begin
            done_d  = 1'b1;
          end else begin
            state_d = FADE;
          end
        end
      end
      FADE: begin
        if (fade_tick) begin
          lvl_r_d = step_r;
          lvl_g_d = step_g;
          lvl_b_d = step_b;
          if (step_r == tgt_r_q && step_g == tgt_g_q && step_b == tgt_b_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; a reset mid-fade simply drops it.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    if (reset) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      strobe_q   <= 1'b0;
      per_cnt_q  <= '0;
      fade_cnt_q <= '0;
      tgt_r_q    <= '0;
      tgt_g_q    <= '0;
      tgt_b_q    <= '0;
      lvl_r_q    <= '0;
      lvl_g_q    <= '0;
      lvl_b_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      strobe_q   <= strobe_d;
      per_cnt_q  <= per_cnt_d;
      fade_cnt_q <= fade_cnt_d;
      tgt_r_q    <= tgt_r_d;
      tgt_g_q    <= tgt_g_d;
      tgt_b_q    <= tgt_b_d;
      lvl_r_q    <= lvl_r_d;
      lvl_g_q    <= lvl_g_d;
      lvl_b_q    <= lvl_b_d;
      done_q     <= done_d;
    end
  end

  assign pwm_strobe = strobe_q;
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == FADE);
  assign done       = done_q;
  assign level_r    = lvl_r_q;
  assign level_g    = lvl_g_q;
  assign level_b    = lvl_b_q;

endmodule
